// File: rtl/ps2_pkg.sv
// Shared scan-code set 2 constants, receiver state encoding and key-map helpers
// for the PS/2 note-key front end.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_SPACE = 8'h29;

    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_F     = 8'h2B;
    localparam logic [7:0] KEY_J     = 8'h3B;
    localparam logic [7:0] KEY_K     = 8'h42;
    localparam logic [7:0] KEY_L     = 8'h4B;
    localparam logic [7:0] KEY_SEMI  = 8'h4C;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } note_hit_t;

    function automatic note_hit_t note_lookup(input logic [7:0] code);
        note_hit_t r;
        r.hit = 1'b1;
        r.idx = 3'd0;
        case (code)
            KEY_A:    r.idx = 3'd0;
            KEY_S:    r.idx = 3'd1;
            KEY_D:    r.idx = 3'd2;
            KEY_F:    r.idx = 3'd3;
            KEY_J:    r.idx = 3'd4;
            KEY_K:    r.idx = 3'd5;
            KEY_L:    r.idx = 3'd6;
            KEY_SEMI: r.idx = 3'd7;
            default:  r.hit = 1'b0;
        endcase
        return r;
    endfunction

    // Scans from the top so the last hit is the lowest set index.
    function automatic logic [2:0] lowest_held(input logic [7:0] held);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (held[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronisers, clock glitch filter, 11-bit frame FSM
// with odd-parity check and an intra-frame idle timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic             clk_s1, clk_s2;
    logic             dat_s1, dat_s2;
    logic             filt;
    logic [FLT_W-1:0] flt_cnt;
    logic             fall;

    rx_state_t        state;
    logic [3:0]       bit_cnt;
    logic [9:0]       frame;
    logic [TO_W-1:0]  to_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b0;
            clk_s2 <= 1'b0;
            dat_s1 <= 1'b0;
            dat_s2 <= 1'b0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered level flips only after FILTER_LEN consecutive samples
    // disagree with it; fall is a one-cycle strobe on a 1->0 flip.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt    <= 1'b0;
            flt_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 == filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                filt    <= clk_s2;
                flt_cnt <= '0;
                fall    <= ~clk_s2;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // frame[0] = start, frame[8:1] = data LSB first, frame[9] = parity;
    // the stop bit is judged directly as it arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RX_IDLE;
            bit_cnt   <= 4'd0;
            frame     <= 10'd0;
            to_cnt    <= '0;
            rx_byte   <= 8'd0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    to_cnt <= '0;
                    if (fall && !dat_s2) begin
                        frame[0] <= 1'b0;
                        bit_cnt  <= 4'd1;
                        state    <= RX_SHIFT;
                    end
                end
                RX_SHIFT: begin
                    if (fall) begin
                        to_cnt <= '0;
                        if (bit_cnt == 4'd10) begin
                            state   <= RX_IDLE;
                            bit_cnt <= 4'd0;
                            if (!frame[0] && dat_s2 && (^frame[9:1])) begin
                                rx_byte  <= frame[8:1];
                                rx_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            frame[bit_cnt] <= dat_s2;
                            bit_cnt        <= bit_cnt + 4'd1;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        frame_err <= 1'b1;
                        state     <= RX_IDLE;
                        bit_cnt   <= 4'd0;
                        to_cnt    <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_note_keys.sv
// Simon Says keyboard front end: turns PS/2 make/break traffic into a held
// bitmap for eight note keys, the current note index and a space-bar level.
module ps2_note_keys
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [2:0] keyCode,
    output logic       keyPressed,
    output logic       spacePressed,
    output logic [7:0] key_held,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    logic      ext;
    logic      brk;
    note_hit_t hit;
    logic [7:0] held_clr;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FILTER_LEN     (FILTER_LEN)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (PS2_CLK),
        .ps2_dat   (PS2_DAT),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    assign hit      = note_lookup(rx_byte);
    assign held_clr = key_held & ~(8'b1 << hit.idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext          <= 1'b0;
            brk          <= 1'b0;
            key_held     <= 8'd0;
            keyPressed   <= 1'b0;
            keyCode      <= 3'd0;
            spacePressed <= 1'b0;
        end else if (frame_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (rx_valid) begin
            case (rx_byte)
                PS2_EXT: ext <= 1'b1;
                PS2_BRK: brk <= 1'b1;
                default: begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!ext && hit.hit) begin
                        if (!brk) begin
                            // Typematic repeats of a held key leave keyCode alone.
                            if (!key_held[hit.idx]) begin
                                key_held[hit.idx] <= 1'b1;
                                keyPressed        <= 1'b1;
                                keyCode           <= hit.idx;
                            end
                        end else begin
                            key_held   <= held_clr;
                            keyPressed <= |held_clr;
                            if (hit.idx == keyCode && (|held_clr))
                                keyCode <= lowest_held(held_clr);
                        end
                    end
                    if (!ext && rx_byte == PS2_SPACE)
                        spacePressed <= ~brk;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_note_keys.sv
// Bench for ps2_note_keys: bit-bangs PS/2 frames and compares against a
// rule-level model of the key state and an expected-byte queue.
module tb_ps2_note_keys;

    localparam int TO_CYC  = 1500;
    localparam int FLT_LEN = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [2:0] keyCode;
    logic       keyPressed, spacePressed;
    logic [7:0] key_held, rx_byte;
    logic       rx_valid, frame_err;

    ps2_note_keys #(.TIMEOUT_CYCLES(TO_CYC), .FILTER_LEN(FLT_LEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .PS2_CLK      (ps2_clk),
        .PS2_DAT      (ps2_dat),
        .keyCode      (keyCode),
        .keyPressed   (keyPressed),
        .spacePressed (spacePressed),
        .key_held     (key_held),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_valid = 0;
    int n_ferr = 0;
    logic [7:0] exp_q[$];

    logic [7:0] note_codes[8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h3B, 8'h42, 8'h4B, 8'h4C};
    logic [7:0] pool[12] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h3B, 8'h42, 8'h4B, 8'h4C,
                             8'hF0, 8'hE0, 8'h29, 8'hAA};

    // Behavioural model state
    logic [7:0] m_held;
    logic [2:0] m_code;
    logic       m_space, m_ext, m_brk;
    logic [7:0] m_rx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                n_valid++;
                if (exp_q.size() > 0) check("rx_byte_q", rx_byte, exp_q.pop_front());
            end
            if (frame_err) n_ferr++;
        end
    end

    task automatic mdl_reset();
        m_held = 8'd0; m_code = 3'd0; m_space = 1'b0;
        m_ext = 1'b0; m_brk = 1'b0; m_rx = 8'd0;
    endtask

    task automatic mdl_apply(input logic [7:0] b);
        int idx;
        m_rx = b;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (!m_ext) begin
                idx = -1;
                for (int i = 0; i < 8; i++) if (note_codes[i] == b) idx = i;
                if (idx >= 0) begin
                    if (!m_brk) begin
                        if (!m_held[idx]) begin
                            m_held[idx] = 1'b1;
                            m_code = 3'(idx);
                        end
                    end else begin
                        m_held[idx] = 1'b0;
                        if (idx == int'(m_code) && m_held != 8'd0)
                            for (int i = 7; i >= 0; i--) if (m_held[i]) m_code = 3'(i);
                    end
                end
                if (b == 8'h29) m_space = !m_brk;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic check_keys(input string tag);
        check({tag, ":keyCode"}, keyCode, m_code);
        check({tag, ":key_held"}, key_held, m_held);
        check({tag, ":keyPressed"}, keyPressed, m_held != 8'd0);
        check({tag, ":spacePressed"}, spacePressed, m_space);
        check({tag, ":rx_byte"}, rx_byte, m_rx);
    endtask

    task automatic drive_bits(input logic [10:0] f, input int nbits, input int h);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            wait_cyc(h);
            ps2_clk = 1'b0;
            wait_cyc(h);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop
    task automatic send_frame(input logic [7:0] b, input int kind, input string tag);
        logic [10:0] f;
        int v0, f0, h;
        f = {(kind == 2) ? 1'b0 : 1'b1, (kind == 1) ? (^b) : ~(^b), b, 1'b0};
        h = $urandom_range(15, 35);
        v0 = n_valid;
        f0 = n_ferr;
        if (kind == 0) exp_q.push_back(b);
        wait_cyc(10);
        drive_bits(f, 11, h);
        for (int k = 0; k < 300 && n_valid == v0 && n_ferr == f0; k++) @(posedge clk);
        wait_cyc(3);
        @(negedge clk);
        check({tag, ":valid_pulses"}, n_valid - v0, (kind == 0) ? 1 : 0);
        check({tag, ":err_pulses"}, n_ferr - f0, (kind == 0) ? 0 : 1);
        if (kind == 0) mdl_apply(b);
        else begin m_ext = 1'b0; m_brk = 1'b0; end
        check_keys(tag);
    endtask

    initial begin
        logic [7:0] b;
        int kind;
        mdl_reset();
        wait_cyc(4);
        check_keys("reset");
        check("reset:rx_valid", rx_valid, 0);
        check("reset:frame_err", frame_err, 0);
        reset = 1'b0;
        wait_cyc(20);

        send_frame(8'h1C, 0, "make_1c");
        send_frame(8'hF0, 0, "brk_pref");
        send_frame(8'h1C, 0, "break_1c");
        send_frame(8'h1C, 0, "make_1c_again");
        send_frame(8'h1C, 0, "repeat_1c");
        send_frame(8'hF0, 0, "brk_pref2");
        send_frame(8'h1C, 0, "break_1c_2");
        send_frame(8'h23, 0, "make_23");
        send_frame(8'h4B, 0, "make_4b");
        send_frame(8'hF0, 0, "brk_pref3");
        send_frame(8'h4B, 0, "break_4b");
        send_frame(8'hF0, 0, "brk_pref4");
        send_frame(8'h23, 0, "break_23");
        send_frame(8'h1C, 1, "bad_parity");

        begin : timeout_case
            int v0, f0;
            v0 = n_valid; f0 = n_ferr;
            wait_cyc(10);
            drive_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5, 20);
            for (int k = 0; k < 3 * TO_CYC && n_ferr == f0; k++) @(posedge clk);
            wait_cyc(3);
            check("timeout:err_pulses", n_ferr - f0, 1);
            check("timeout:valid_pulses", n_valid - v0, 0);
            check_keys("timeout");
        end

        send_frame(8'h29, 0, "make_space");
        send_frame(8'hF0, 0, "brk_pref5");
        send_frame(8'h29, 0, "break_space");
        send_frame(8'hE0, 0, "ext_pref");
        send_frame(8'h1C, 0, "ext_1c");
        send_frame(8'h1C, 0, "post_ext_1c");

        begin : reset_mid_frame
            wait_cyc(10);
            drive_bits({1'b1, 1'b0, 8'h3B, 1'b0}, 4, 20);
            #2 reset = 1'b1;
            #1;
            mdl_reset();
            check_keys("reset_mid");
            wait_cyc(5);
            reset = 1'b0;
            wait_cyc(20);
        end
        send_frame(8'h1B, 0, "after_reset_1b");

        for (int i = 0; i < 40; i++) begin
            b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
            kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            send_frame(b, kind, "rand");
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
